// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : timer_pkg
// Description : Shared definitions for the microwave cook-timer controller.
//               Includes the FSM state encodings, BCD digit limits, the packed
//               four-digit time record, and a zero-time helper.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // FSM state encodings. These values are exported on the State debug port.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTING = 3'd1;
    localparam logic [2:0] ST_RUNNING = 3'd2;
    localparam logic [2:0] ST_PAUSED  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // BCD limits
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam logic [3:0] KEY_MAX  = 4'd9;

    // Displayed time, most significant digit first
    typedef struct packed {
        logic [3:0] ten_min;
        logic [3:0] min;
        logic [3:0] ten_sec;
        logic [3:0] sec;
    } bcd_time_t;

    function automatic logic time_is_zero(input bcd_time_t t);
        return (t == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_down.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_down
// Description : One stage of a BCD down-counter chain. When BorrowIn is set,
//               the stage decrements Digit. At zero it wraps to Max and raises
//               BorrowOut. Purely combinational.
// Ports       : Digit     in  4  current digit value
//               BorrowIn  in  1  decrement request from the less significant stage
//               Max       in  4  wrap value for this digit position
//               Next      out 4  digit value after the (optional) decrement
//               BorrowOut out 1  borrow into the more significant stage
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_down (
    input  logic [3:0] Digit,
    input  logic       BorrowIn,
    input  logic [3:0] Max,
    output logic [3:0] Next,
    output logic       BorrowOut
);

    always_comb begin
        Next      = Digit;
        BorrowOut = 1'b0;
        if (BorrowIn) begin
            if (Digit == 4'd0) begin
                Next      = Max;
                BorrowOut = 1'b1;
            end else begin
                // Digits above Max (e.g. TenSec of 0:90) simply count down
                Next = Digit - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cook_timer_ctrl
// Description : Microwave cook-timer controller. This module handles the
//               following:
//               - Owns the four BCD display digits.
//               - Shifts in keypad entries.
//               - Counts down once every TICK_DIV clocks while cooking.
//               - Drives the magnetron enable.
//               - Pulses Done when the count reaches zero.
//               Optional build macro DISPLAY_BLINK_EN: when it is defined,
//               Blank toggles every TICK_DIV/2 clocks while PAUSED or DONE.
//               When it is undefined, Blank is tied low.
// Ports       : Clk          in  1  system clock (rising edge)
//               nReset       in  1  asynchronous active-low reset
//               KeyValid     in  1  strobe, KeyDigit valid
//               KeyDigit     in  4  keypad BCD digit (10..15 ignored)
//               StartBtn     in  1  strobe, start / resume
//               StopBtn      in  1  strobe, pause / clear
//               DoorOpen     in  1  level, door open
//               TenMin/Min   out 4  BCD minute digits
//               TenSec/Sec   out 4  BCD second digits
//               MagnetronOn  out 1  high while RUNNING
//               Done         out 1  one-cycle pulse on entry to DONE
//               State        out 3  FSM state (debug)
//               Blank        out 1  display blank request
// Revision    : 1.0 - initial release
// ============================================================================
module cook_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       KeyValid,
    input  logic [3:0] KeyDigit,
    input  logic       StartBtn,
    input  logic       StopBtn,
    input  logic       DoorOpen,
    output logic [3:0] TenMin,
    output logic [3:0] Min,
    output logic [3:0] TenSec,
    output logic [3:0] Sec,
    output logic       MagnetronOn,
    output logic       Done,
    output logic [2:0] State,
    output logic       Blank
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_next;
    bcd_time_t        digits;
    bcd_time_t        dec_time;
    logic [PRE_W-1:0] prescaler;
    logic             done_r;

    logic             tick;
    logic             time_zero;
    logic             dec_zero;
    logic             key_ok;
    logic             start_ok;
    logic             load_key;
    logic             clear_digits;
    logic             do_dec;

    logic             borrow_sec;
    logic             borrow_ten_sec;
    logic             borrow_min;
    logic             borrow_top;

    // ------------------------------------------------------------------------
    // Countdown chain: seconds wrap to 9, tens of seconds wrap to 5,
    // minutes and tens of minutes wrap to 9.
    // ------------------------------------------------------------------------
    bcd_digit_down u_sec (
        .Digit     (digits.sec),
        .BorrowIn  (1'b1),
        .Max       (BCD_NINE),
        .Next      (dec_time.sec),
        .BorrowOut (borrow_sec)
    );

    bcd_digit_down u_ten_sec (
        .Digit     (digits.ten_sec),
        .BorrowIn  (borrow_sec),
        .Max       (BCD_FIVE),
        .Next      (dec_time.ten_sec),
        .BorrowOut (borrow_ten_sec)
    );

    bcd_digit_down u_min (
        .Digit     (digits.min),
        .BorrowIn  (borrow_ten_sec),
        .Max       (BCD_NINE),
        .Next      (dec_time.min),
        .BorrowOut (borrow_min)
    );

    bcd_digit_down u_ten_min (
        .Digit     (digits.ten_min),
        .BorrowIn  (borrow_min),
        .Max       (BCD_NINE),
        .Next      (dec_time.ten_min),
        .BorrowOut (borrow_top)
    );

    assign time_zero = time_is_zero(digits);
    assign dec_zero  = time_is_zero(dec_time);
    assign tick      = (state == ST_RUNNING) && (prescaler == PRE_LAST);
    assign key_ok    = KeyValid && (KeyDigit <= KEY_MAX);
    assign start_ok  = StartBtn && !DoorOpen && !time_zero;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Within a state, only the highest-priority asserted
    // strobe is acted on: Stop > Door > Start > Key. DoorOpen acts as an
    // event only while RUNNING. In other states it merely blocks Start.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        load_key     = 1'b0;
        clear_digits = 1'b0;
        do_dec       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (StopBtn || StartBtn) begin
                    state_next = ST_IDLE;
                end else if (key_ok) begin
                    load_key   = 1'b1;
                    state_next = ST_SETTING;
                end
            end
            ST_SETTING: begin
                if (StopBtn) begin
                    clear_digits = 1'b1;
                    state_next   = ST_IDLE;
                end else if (StartBtn) begin
                    if (start_ok) begin
                        state_next = ST_RUNNING;
                    end
                end else if (key_ok) begin
                    load_key = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (StopBtn || DoorOpen) begin
                    state_next = ST_PAUSED;
                end else if (tick && !borrow_top) begin
                    // borrow_top set means the digits are 0000.
                    // Never wrap below zero.
                    do_dec = 1'b1;
                    if (dec_zero) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_PAUSED: begin
                if (StopBtn) begin
                    clear_digits = 1'b1;
                    state_next   = ST_IDLE;
                end else if (start_ok) begin
                    state_next = ST_RUNNING;
                end
            end
            ST_DONE: begin
                if (StopBtn || KeyValid) begin
                    clear_digits = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                clear_digits = 1'b1;
                state_next   = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: digits, prescaler, done pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            digits <= '0;
        end else if (clear_digits) begin
            digits <= '0;
        end else if (load_key) begin
            digits <= '{ten_min: digits.min,
                        min:     digits.ten_sec,
                        ten_sec: digits.sec,
                        sec:     KeyDigit};
        end else if (do_dec) begin
            digits <= dec_time;
        end
    end

    // The prescaler runs only across RUNNING-to-RUNNING edges. As a result,
    // the first step after entering or resuming RUNNING lands a full
    // TICK_DIV cycles later.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            prescaler <= '0;
        end else if ((state == ST_RUNNING) && (state_next == ST_RUNNING) && !tick) begin
            prescaler <= prescaler + PRE_ONE;
        end else begin
            prescaler <= '0;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_next == ST_DONE) && (state != ST_DONE);
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int               HALF      = TICK_DIV / 2;
    localparam int               BLK_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(HALF - 1);
    localparam logic [BLK_W-1:0] BLK_ONE   = BLK_W'(1);

    logic [BLK_W-1:0] blink_cnt;
    logic             blank_r;
    logic             blink_state;

    assign blink_state = (state_next == ST_PAUSED) || (state_next == ST_DONE);

    // Restarts on every state change, so blanking always begins lit
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            blink_cnt <= '0;
            blank_r   <= 1'b0;
        end else if (!blink_state || (state_next != state)) begin
            blink_cnt <= '0;
            blank_r   <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blank_r   <= ~blank_r;
        end else begin
            blink_cnt <= blink_cnt + BLK_ONE;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        TenMin      = digits.ten_min;
        Min         = digits.min;
        TenSec      = digits.ten_sec;
        Sec         = digits.sec;
        MagnetronOn = (state == ST_RUNNING);
        Done        = done_r;
        State       = state;
`ifdef DISPLAY_BLINK_EN
        Blank       = blank_r;
`else
        Blank       = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cook_timer_ctrl
// Description : Directed self-checking bench for cook_timer_ctrl
//               (TICK_DIV = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cook_timer_ctrl;

    localparam int TICK_DIV = 4;
`ifdef DISPLAY_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    logic       Clk      = 1'b0;
    logic       nReset   = 1'b0;
    logic       KeyValid = 1'b0;
    logic [3:0] KeyDigit = 4'd0;
    logic       StartBtn = 1'b0;
    logic       StopBtn  = 1'b0;
    logic       DoorOpen = 1'b0;
    logic [3:0] TenMin, Min, TenSec, Sec;
    logic       MagnetronOn, Done, Blank;
    logic [2:0] State;
    logic [15:0] disp;

    int total = 0;
    int bad   = 0;

    assign disp = {TenMin, Min, TenSec, Sec};

    cook_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .Clk         (Clk),
        .nReset      (nReset),
        .KeyValid    (KeyValid),
        .KeyDigit    (KeyDigit),
        .StartBtn    (StartBtn),
        .StopBtn     (StopBtn),
        .DoorOpen    (DoorOpen),
        .TenMin      (TenMin),
        .Min         (Min),
        .TenSec      (TenSec),
        .Sec         (Sec),
        .MagnetronOn (MagnetronOn),
        .Done        (Done),
        .State       (State),
        .Blank       (Blank)
    );

    initial forever #5 Clk = ~Clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        KeyValid = 1'b1;
        KeyDigit = d;
        step(1);
        KeyValid = 1'b0;
    endtask

    task automatic start();
        StartBtn = 1'b1;
        step(1);
        StartBtn = 1'b0;
    endtask

    task automatic stop();
        StopBtn = 1'b1;
        step(1);
        StopBtn = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_digits", disp, 16'h0000);
        chk("rst_state", 16'(State), 16'd0);
        chk("rst_mag", 16'(MagnetronOn), 16'd0);
        chk("rst_done", 16'(Done), 16'd0);
        chk("rst_blank", 16'(Blank), 16'd0);
        nReset = 1'b1;
        step(1);

        // Entry 1,3,0 and countdown with borrow
        key(4'd1);
        chk("key1_state", 16'(State), 16'd1);
        chk("key1_digits", disp, 16'h0001);
        key(4'd3);
        key(4'd0);
        chk("key130_digits", disp, 16'h0130);
        start();
        chk("run_state", 16'(State), 16'd2);
        chk("run_mag", 16'(MagnetronOn), 16'd1);
        step(3);
        chk("run_3clk", disp, 16'h0130);
        step(1);
        chk("run_4clk", disp, 16'h0129);
        step(116);
        chk("run_120clk", disp, 16'h0100);
        step(4);
        chk("run_124clk", disp, 16'h0059);

        // Stop pauses, second Stop clears
        stop();
        chk("stop1_state", 16'(State), 16'd3);
        chk("stop1_mag", 16'(MagnetronOn), 16'd0);
        step(6);
        chk("stop1_held", disp, 16'h0059);
        stop();
        chk("stop2_state", 16'(State), 16'd0);
        chk("stop2_digits", disp, 16'h0000);
        start();
        chk("idle_start", 16'(State), 16'd0);
        key(4'd12);
        chk("key12_state", 16'(State), 16'd0);
        chk("key12_digits", disp, 16'h0000);

        // Run 0:05 to completion
        key(4'd0);
        chk("key0_state", 16'(State), 16'd1);
        start();
        chk("start_zero_ign", 16'(State), 16'd1);
        key(4'd5);
        start();
        step(19);
        chk("pre_done_digits", disp, 16'h0001);
        chk("pre_done_pulse", 16'(Done), 16'd0);
        step(1);
        chk("done_digits", disp, 16'h0000);
        chk("done_state", 16'(State), 16'd4);
        chk("done_pulse", 16'(Done), 16'd1);
        chk("done_mag", 16'(MagnetronOn), 16'd0);
        step(1);
        chk("done_pulse_end", 16'(Done), 16'd0);
        chk("done_stay", 16'(State), 16'd4);
        key(4'd7);
        chk("done_key_state", 16'(State), 16'd0);
        chk("done_key_digits", disp, 16'h0000);

        // Door interlock on 0:10
        key(4'd1);
        key(4'd0);
        start();
        step(2);
        DoorOpen = 1'b1;
        step(1);
        chk("door_state", 16'(State), 16'd3);
        chk("door_held", disp, 16'h0010);
        start();
        chk("door_start_ign", 16'(State), 16'd3);
        DoorOpen = 1'b0;
        start();
        chk("resume_state", 16'(State), 16'd2);
        chk("run_blank", 16'(Blank), 16'd0);
        step(3);
        chk("resume_3clk", disp, 16'h0010);
        step(1);
        chk("resume_4clk", disp, 16'h0009);

        // Blink while paused
        stop();
        chk("blink0", 16'(Blank), 16'd0);
        step(1);
        chk("blink1", 16'(Blank), 16'd0);
        step(1);
        chk("blink2", 16'(Blank), 16'(BLINK));
        step(1);
        chk("blink3", 16'(Blank), 16'(BLINK));
        step(1);
        chk("blink4", 16'(Blank), 16'd0);

        // Start+Stop together in PAUSED
        StartBtn = 1'b1;
        StopBtn  = 1'b1;
        step(1);
        StartBtn = 1'b0;
        StopBtn  = 1'b0;
        chk("startstop_state", 16'(State), 16'd0);
        chk("startstop_digits", disp, 16'h0000);

        // Max time 99:99
        key(4'd9);
        key(4'd9);
        key(4'd9);
        key(4'd9);
        chk("max_digits", disp, 16'h9999);
        start();
        step(4);
        chk("max_1dec", disp, 16'h9998);
        step(36);
        chk("max_10dec", disp, 16'h9989);
        stop();
        stop();

        // Reset mid-run
        key(4'd2);
        start();
        step(4);
        chk("mid_digits", disp, 16'h0001);
        chk("mid_mag", 16'(MagnetronOn), 16'd1);
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_digits", disp, 16'h0000);
        chk("arst_state", 16'(State), 16'd0);
        chk("arst_mag", 16'(MagnetronOn), 16'd0);
        chk("arst_done", 16'(Done), 16'd0);
        #3;
        nReset = 1'b1;
        step(2);
        chk("post_rst_state", 16'(State), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
